// File: rtl/sram_operand_unpacker_pkg.sv
// unpack_pkg: shared state encoding, header offsets and width helpers for the operand unpacker.
// Revision 1.0
`default_nettype none

package unpack_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CNT  = 3'd1,
    S_RD_SIZE = 3'd2,
    S_CHK     = 3'd3,
    S_FETCH   = 3'd4,
    S_LOAD    = 3'd5,
    S_EMIT    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam int CNT_OFS     = 0;
  localparam int SIZE_OFS    = 1;
  localparam int PAYLOAD_OFS = 2;

  function automatic logic width_legal(input logic [4:0] w);
    return (w == 5'd1) || (w == 5'd2) || (w == 5'd4) || (w == 5'd8);
  endfunction

  function automatic logic [4:0] elems_per_word(input logic [4:0] w);
    case (w)
      5'd1:    return 5'd16;
      5'd2:    return 5'd8;
      5'd4:    return 5'd4;
      5'd8:    return 5'd2;
      default: return 5'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_operand_unpacker_shift_reg.sv
// unpack_shift_reg: 16-bit payload shift register with per-word element counter and MSB field tap.
// Revision 1.0
`default_nettype none

module unpack_shift_reg
  import unpack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [4:0]  width,
  input  logic [15:0] load_data,
  output logic [7:0]  field,
  output logic        last_in_word
);

  logic [15:0] sh_d, sh_q;
  logic [4:0]  cnt_d, cnt_q;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data;
      cnt_d = elems_per_word(width);
    end else if (shift) begin
      sh_d  = sh_q << width;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  // Elements are taken from the top of the register, zero-extended to a byte.
  always_comb begin
    field = 8'h00;
    case (width)
      5'd1:    field = {7'b0, sh_q[15]};
      5'd2:    field = {6'b0, sh_q[15:14]};
      5'd4:    field = {4'b0, sh_q[15:12]};
      5'd8:    field = sh_q[15:8];
      default: field = 8'h00;
    endcase
  end

  assign last_in_word = (cnt_q == 5'd1);

endmodule

`default_nettype wire

// File: rtl/sram_operand_unpacker.sv
// sram_operand_unpacker: reads a count/width header and packed payload from SRAM, emits one element per handshake.
// Revision 1.0
`default_nettype none

module sram_operand_unpacker
  import unpack_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [7:0]        elem_data,
  output logic [15:0]       elem_index,
  output logic              elem_last
);

  localparam logic [ADDR_W-1:0] CNT_ADDR  = ADDR_W'(BASE_ADDR + CNT_OFS);
  localparam logic [ADDR_W-1:0] SIZE_ADDR = ADDR_W'(BASE_ADDR + SIZE_OFS);
  localparam logic [ADDR_W-1:0] PAY_ADDR  = ADDR_W'(BASE_ADDR + PAYLOAD_OFS);

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic [15:0]       n_d, n_q;
  logic [15:0]       rem_d, rem_q;
  logic [15:0]       idx_d, idx_q;
  logic [4:0]        w_d, w_q;
  logic              err_d, err_q;
  logic              sr_load, sr_shift;
  logic [7:0]        sr_field;
  logic              sr_last_in_word;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    n_d      = n_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    w_d      = w_q;
    err_d    = err_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_CNT;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_RD_CNT:  state_d = S_RD_SIZE;
      S_RD_SIZE: begin
        n_d     = rd_data;
        state_d = S_CHK;
      end
      S_CHK: begin
        w_d   = rd_data[4:0];
        ptr_d = PAY_ADDR;
        rem_d = n_q;
        if (!width_legal(rd_data[4:0])) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (n_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        sr_load = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (elem_ready) begin
          sr_shift = 1'b1;
          rem_d    = rem_q - 16'd1;
          idx_d    = idx_q + 16'd1;
          // Region end takes priority so no word past the last element is fetched.
          if (rem_q == 16'd1) begin
            state_d = S_DONE;
          end else if (sr_last_in_word) begin
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      err_q   <= err_d;
    end
  end

  unpack_shift_reg u_shift_reg (
    .clk          (clk),
    .reset        (reset),
    .load         (sr_load),
    .shift        (sr_shift),
    .width        (w_q),
    .load_data    (rd_data),
    .field        (sr_field),
    .last_in_word (sr_last_in_word)
  );

  always_comb begin
    rd_addr = '0;
    case (state_q)
      S_RD_CNT:  rd_addr = CNT_ADDR;
      S_RD_SIZE: rd_addr = SIZE_ADDR;
      S_FETCH:   rd_addr = ptr_q;
      default:   rd_addr = '0;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign rd_en      = (state_q == S_RD_CNT) || (state_q == S_RD_SIZE) || (state_q == S_FETCH);
  assign elem_valid = (state_q == S_EMIT);
  assign elem_data  = (state_q == S_EMIT) ? sr_field : 8'h00;
  assign elem_index = idx_q;
  assign elem_last  = (state_q == S_EMIT) && (rem_q == 16'd1);

endmodule

`default_nettype wire

// File: tb/tb_sram_operand_unpacker.sv
// tb_sram_operand_unpacker: table-driven regions with an SRAM model and element scoreboard.
// Revision 1.0
`default_nettype none

module tb_sram_operand_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, rd_en;
  logic [11:0] rd_addr;
  logic [15:0] rd_data = 16'h0;
  logic        elem_valid;
  logic        elem_ready = 1'b1;
  logic [7:0]  elem_data;
  logic [15:0] elem_index;
  logic        elem_last;

  sram_operand_unpacker #(.BASE_ADDR(0), .ADDR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_data  (elem_data),
    .elem_index (elem_index),
    .elem_last  (elem_last)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] i;
    logic        l;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0]       n;
    logic [15:0]       w;
    logic [3:0][15:0]  pay;
    int                stall_idx;
    int                stall_len;
    bit                poke;
    bit                exp_err;
    int                exp_pay_reads;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] n, input logic [15:0] w,
                              input logic [15:0] p0, input logic [15:0] p1,
                              input int si, input int sl, input bit pk,
                              input bit ee, input int pr);
    vec_t v;
    v.n = n; v.w = w;
    v.pay = {16'hFFFF, 16'hFFFF, p1, p0};
    v.stall_idx = si; v.stall_len = sl; v.poke = pk;
    v.exp_err = ee; v.exp_pay_reads = pr;
    return v;
  endfunction

  // Monitor state, armed per region by run_region.
  bit mon_en = 1'b0;
  bit mon_exp_err;
  int mon_s, mon_nreads, mon_exp_addr, mon_ndone, mon_done_cyc, mon_first_valid;
  bit mon_prev_done;

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(mon_exp_addr));
        mon_exp_addr++;
        mon_nreads++;
      end
      if (elem_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_elem", 32'(elem_index), 32'hFFFF_FFFF);
        end else begin
          chk("elem_data", 32'(elem_data), 32'(sb[0].d));
          chk("elem_index", 32'(elem_index), 32'(sb[0].i));
          chk("elem_last", 32'(elem_last), 32'(sb[0].l));
          if (mon_first_valid < 0) mon_first_valid = cyc - mon_s;
          if (elem_ready) void'(sb.pop_front());
        end
      end
      if (done) begin
        mon_ndone++;
        mon_done_cyc = cyc - mon_s;
        chk("err_at_done", 32'(err), 32'(mon_exp_err));
      end
      if (mon_prev_done) chk("busy_after_done", 32'(busy), 32'd0);
      mon_prev_done = done;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_elem_valid"}, 32'(elem_valid), 0);
    chk({tag, "_elem_data"}, 32'(elem_data), 0);
    chk({tag, "_elem_index"}, 32'(elem_index), 0);
    chk({tag, "_elem_last"}, 32'(elem_last), 0);
  endtask

  task automatic run_region(input vec_t v, input int rst_at);
    int stall_left;
    bit finished;
    int wv;
    mem[0] = v.n;
    mem[1] = v.w;
    for (int k = 0; k < 4; k++) mem[2 + k] = v.pay[k];
    sb.delete();
    wv = int'(v.w);
    // Element i starts at global bit i*W counted from the MSB of the first payload word.
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.n); i++) begin
        int bp, wd, off;
        logic [15:0] word, val;
        exp_t e;
        bp = i * wv; wd = bp / 16; off = bp % 16;
        word = v.pay[wd];
        val = (word >> (16 - off - wv)) & 16'((1 << wv) - 1);
        e.d = val[7:0]; e.i = 16'(i); e.l = (i == int'(v.n) - 1);
        sb.push_back(e);
      end
    end
    mon_exp_err = v.exp_err;
    mon_nreads = 0; mon_exp_addr = 0; mon_ndone = 0;
    mon_done_cyc = -1; mon_first_valid = -1; mon_prev_done = 1'b0;
    stall_left = v.stall_len;
    finished = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    mon_s = cyc;
    start = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(posedge clk); #1;
      start = (v.poke && k == 6);
      if (rst_at >= 0 && elem_valid && int'(elem_index) == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_mid_emit");
        reset = 1'b0;
        mon_en = 1'b0;
        sb.delete();
        return;
      end
      if (elem_valid && int'(elem_index) == v.stall_idx && stall_left > 0) begin
        elem_ready = 1'b0;
        stall_left--;
      end else begin
        elem_ready = 1'b1;
      end
      if (mon_ndone > 0) finished = 1'b1;
    end
    start = 1'b0;
    elem_ready = 1'b1;
    if (!finished) chk("timeout_done", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("done_count", 32'(mon_ndone), 32'd1);
    chk("read_count", 32'(mon_nreads), 32'(2 + v.exp_pay_reads));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("err_held", 32'(err), 32'(v.exp_err));
    if (v.exp_err || v.n == 0) chk("done_cycle", 32'(mon_done_cyc), 32'd3);
    else chk("first_valid_cycle", 32'(mon_first_valid), 32'd5);
  endtask

  vec_t vecs [7];

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'hDEAD;
    //            N      W      p0        p1        stall  len poke err reads
    vecs[0] = mk(16'd4,  16'd8, 16'h1234, 16'hABCD, -1,    0,  0,   0,  2);
    vecs[1] = mk(16'd5,  16'd2, 16'hE400, 16'hFFFF, -1,    0,  0,   0,  1);
    vecs[2] = mk(16'd16, 16'd1, 16'h8001, 16'hFFFF, -1,    0,  0,   0,  1);
    vecs[3] = mk(16'd0,  16'd8, 16'h1111, 16'h2222, -1,    0,  0,   0,  0);
    vecs[4] = mk(16'd7,  16'd3, 16'h1111, 16'h2222, -1,    0,  0,   1,  0);
    vecs[5] = mk(16'd4,  16'd4, 16'h5A3C, 16'hFFFF,  1,    3,  0,   0,  1);
    vecs[6] = mk(16'd3,  16'd8, 16'hAA55, 16'h0F00, -1,    0,  1,   0,  2);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;

    for (int t = 0; t < 7; t++) run_region(vecs[t], -1);

    // Illegal region leaves err set; a reset mid-EMIT then drops everything.
    run_region(vecs[4], -1);
    run_region(vecs[0], 1);
    run_region(vecs[0], -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
